gate_truth_table_prober: RTL and testbench

// Drives all four input combinations into one external 2-input gate (AND, OR, NAND,
// NOR, XOR, XNOR, NOT-of-I1, Buffer-of-I1) and waits a settle time after each.

---
 rtl/gate_truth_table_prober_if.sv | 22 ++
 rtl/gate_truth_table_prober.sv | 97 +++++++++
 tb/tb_gate_truth_table_prober.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/gate_truth_table_prober_if.sv
// Handshake and gate-under-test pins of the truth-table prober.
// The slave modport is the prober side; the master modport is the requester plus gate.
interface gate_truth_table_prober_if;
    logic       start;
    logic       i1;
    logic       i2;
    logic       gate_o;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic [3:0] gate_id;

    modport slave (
        input  start, gate_o,
        output i1, i2, busy, done, truth_table, gate_id
    );

    modport master (
        output start, gate_o,
        input  i1, i2, busy, done, truth_table, gate_id
    );
endinterface

// File: rtl/gate_truth_table_prober.sv
// Walks {i1,i2} through 00..11 into an external 2-input gate, samples its output
// after a settle time per vector, and classifies the resulting 4-bit truth table.
module gate_truth_table_prober #(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input logic                        clk,
    input logic                        rst,
    gate_truth_table_prober_if.slave   bus
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SETTLE = 1'b1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [0:0]       state;
    logic [1:0]       vec;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       shadow;
    logic [1:0]       drv;
    logic             busy_r;
    logic             done_r;
    logic [3:0]       tt_r;
    logic [3:0]       id_r;
    logic [3:0]       tt_next;

    // Table bit k is the gate output for {I1,I2}=k.
    function automatic logic [3:0] classify(input logic [3:0] tt);
        case (tt)
            4'b1000: classify = 4'h0;
            4'b1110: classify = 4'h1;
            4'b0011: classify = 4'h2;
            4'b0111: classify = 4'h3;
            4'b0001: classify = 4'h4;
            4'b0110: classify = 4'h5;
            4'b1001: classify = 4'h6;
            4'b1100: classify = 4'h7;
            default: classify = 4'hF;
        endcase
    endfunction

    assign tt_next = {bus.gate_o, shadow};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            vec    <= 2'd0;
            cnt    <= '0;
            shadow <= 3'b000;
            drv    <= 2'b00;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            tt_r   <= 4'h0;
            id_r   <= 4'hF;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= SETTLE;
                        vec    <= 2'd0;
                        cnt    <= '0;
                        drv    <= 2'b00;
                        busy_r <= 1'b1;
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (vec != 2'd3) begin
                            shadow[vec] <= bus.gate_o;
                            vec         <= vec + 2'd1;
                            drv         <= vec + 2'd1;
                        end else begin
                            // Last vector: gate_o goes straight into the result.
                            tt_r   <= tt_next;
                            id_r   <= classify(tt_next);
                            done_r <= 1'b1;
                            busy_r <= 1'b0;
                            drv    <= 2'b00;
                            state  <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.i1          = drv[1];
    assign bus.i2          = drv[0];
    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.truth_table = tt_r;
    assign bus.gate_id     = id_r;
endmodule

// File: tb/tb_gate_truth_table_prober.sv
// Bench for gate_truth_table_prober: behavioural gate models, scoreboard of expected
// {truth_table, gate_id} results popped on each done pulse.
module tb_gate_truth_table_prober;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   model  = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    gate_truth_table_prober_if bus ();

    gate_truth_table_prober #(.SETTLE_CYCLES(2), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 0 AND,1 OR,2 NOT,3 NAND,4 NOR,5 XOR,6 XNOR,7 BUF,8 tied1,9 tied0
    function automatic logic gate_model(input int m, input logic a, input logic b);
        case (m)
            0: gate_model = a & b;
            1: gate_model = a | b;
            2: gate_model = ~a;
            3: gate_model = ~(a & b);
            4: gate_model = ~(a | b);
            5: gate_model = a ^ b;
            6: gate_model = ~(a ^ b);
            7: gate_model = a;
            8: gate_model = 1'b1;
            default: gate_model = 1'b0;
        endcase
    endfunction

    assign bus.gate_o = gate_model(model, bus.i1, bus.i2);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : sb
        logic [7:0] e;
        if (bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 8'(bus.done), 8'h00);
            end else begin
                e = exp_q.pop_front();
                chk("truth_table", {4'h0, bus.truth_table}, {4'h0, e[7:4]});
                chk("gate_id", {4'h0, bus.gate_id}, {4'h0, e[3:0]});
            end
        end
    end

    // Start at E0, optionally pulse start again at negedge k (sampled at E0+k+1).
    task automatic probe(input int m, input logic [3:0] tt, input logic [3:0] id,
                         input int extra_k);
        bit seen;
        model = m;
        exp_q.push_back({tt, id});
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk);
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            bus.start = (k == extra_k);
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                chk("done_latency", 8'(k), 8'd8);
                chk("busy_at_done", 8'(bus.busy), 8'd0);
                chk("vec_at_done", 8'({bus.i1, bus.i2}), 8'd0);
            end else if (k < 8) begin
                chk("vec", 8'({bus.i1, bus.i2}), 8'(k / 2));
                chk("busy", 8'(bus.busy), 8'd1);
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        if (!seen) begin
            chk("done_timeout", 8'd0, 8'd1);
            exp_q.delete();
        end else begin
            chk("done_one_cycle", 8'(bus.done), 8'd0);
        end
    endtask

    initial begin
        bit seen;
        rst       = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_vec", 8'({bus.i1, bus.i2}), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_tt", {4'h0, bus.truth_table}, 8'h00);
        chk("rst_id", {4'h0, bus.gate_id}, 8'h0F);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_busy", 8'(bus.busy), 8'd0);

        probe(0, 4'b1000, 4'h0, -1);
        probe(1, 4'b1110, 4'h1, -1);
        probe(2, 4'b0011, 4'h2, -1);
        probe(3, 4'b0111, 4'h3, -1);
        probe(4, 4'b0001, 4'h4, -1);
        probe(5, 4'b0110, 4'h5, -1);
        probe(6, 4'b1001, 4'h6, -1);
        probe(7, 4'b1100, 4'h7, -1);
        probe(8, 4'b1111, 4'hF, -1);
        probe(9, 4'b0000, 4'hF, -1);
        // start re-pulsed while busy must not extend or queue a probe
        probe(0, 4'b1000, 4'h0, 2);
        repeat (12) @(negedge clk);
        chk("no_queued_busy", 8'(bus.busy), 8'd0);

        // reset mid-probe: abort, no done
        model = 5;
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_vec", 8'({bus.i1, bus.i2}), 8'd0);
        chk("abort_busy", 8'(bus.busy), 8'd0);
        chk("abort_id", {4'h0, bus.gate_id}, 8'h0F);
        chk("abort_tt", {4'h0, bus.truth_table}, 8'h00);
        chk("abort_done", 8'(bus.done), 8'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_idle", 8'(bus.busy), 8'd0);
        probe(5, 4'b0110, 4'h5, -1);

        // start held through done: restart the cycle right after done
        model = 1;
        exp_q.push_back({4'b1110, 4'h1});
        exp_q.push_back({4'b1110, 4'h1});
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk);
        repeat (8) @(negedge clk);
        chk("held_done", 8'(bus.done), 8'd1);
        chk("held_busy_gap", 8'(bus.busy), 8'd0);
        @(negedge clk);
        chk("held_restart", 8'(bus.busy), 8'd1);
        chk("held_restart_vec", 8'({bus.i1, bus.i2}), 8'd0);
        bus.start = 1'b0;
        seen = 1'b0;
        for (int k = 9; k < 40 && !seen; k++) begin
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                chk("held_second_done", 8'(k), 8'd17);
            end
            if (!seen) @(negedge clk);
        end
        if (!seen) chk("held_timeout", 8'd0, 8'd1);
        repeat (2) @(negedge clk);
        chk("sb_empty", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
